// File: rtl/adc_buf_pkg.sv
// Shared types for the ADC trigger-window buffer.
// Default sample word shape and the readout FSM states.
package adc_buf_pkg;

  localparam int N_CH_DEF     = 64;
  localparam int SAMPLE_W_DEF = 12;

  typedef logic [N_CH_DEF-1:0][SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

endpackage

// File: rtl/adc_ring_ram.sv
// Simple dual-port ring RAM: synchronous write, registered read.
// The read register holds its value when no read is issued.
module adc_ring_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 768,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    mem[wr_addr] <= wr_data;
  end

  // Only the read register is cleared; the array itself is never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/adc_window_buffer.sv
// Circular ADC sample buffer with trigger-driven window readout.
// Writes every cycle; streams a past window over valid/ready.
module adc_window_buffer
  import adc_buf_pkg::*;
#(
  parameter int N_CH     = 64,
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 128,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int WIN_W    = 8
) (
  input  logic                               adc_clk,
  input  logic                               rst_n,
  input  logic [N_CH-1:0][SAMPLE_W-1:0]      adc_data,
  input  logic                               trigger,
  input  logic [PTR_W-1:0]                   trigger_latency,
  input  logic [WIN_W-1:0]                   window_len,
  output logic [N_CH-1:0][SAMPLE_W-1:0]      out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_first,
  output logic                               out_last,
  output logic                               out_abort,
  output logic                               busy,
  output logic                               overrun,
  output logic [15:0]                        dropped_cnt,
  input  logic                               clr_status
);

  localparam int W = N_CH * SAMPLE_W;
  localparam logic [PTR_W-1:0] L_MAX   = PTR_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] OCC_MAX = PTR_W'(DEPTH - 1);

  state_t state, state_nx;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] lat;
  logic [PTR_W-1:0] occ;
  logic [WIN_W-1:0] remaining;
  logic             first_pend;
  logic             accept;
  logic             issue;
  logic             abort;
  logic             fire;
  logic             done;
  logic [W-1:0]     rd_word;

  assign busy   = (state == READ);
  assign lat    = (trigger_latency > L_MAX) ? L_MAX : trigger_latency;
  assign occ    = wr_ptr - rd_ptr;
  assign accept = !busy && trigger && (window_len != '0);
  assign fire   = out_valid && out_ready;
  assign done   = fire && out_last;
  assign issue  = busy && (remaining != '0) && (!out_valid || out_ready);
  // Only a stalled window can fall behind the writer by a full ring.
  assign abort  = busy && (remaining != '0) && !issue && (occ == OCC_MAX);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = READ;
      READ: if (done)   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      remaining  <= '0;
      first_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_abort  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (accept) begin
        rd_ptr     <= wr_ptr - lat;
        remaining  <= window_len;
        first_pend <= 1'b1;
      end else if (issue) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        remaining  <= remaining - WIN_W'(1);
        first_pend <= 1'b0;
      end else if (abort) begin
        remaining  <= '0;
      end
      if (issue) begin
        out_valid <= 1'b1;
        out_first <= first_pend;
        out_last  <= (remaining == WIN_W'(1));
        out_abort <= 1'b0;
      end else if (fire) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        out_abort <= 1'b0;
      end else if (abort) begin
        out_last  <= 1'b1;
        out_abort <= 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      dropped_cnt <= '0;
    end else if (clr_status) begin
      overrun     <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      if (abort) overrun <= 1'b1;
      if (busy && trigger && dropped_cnt != 16'hFFFF)
        dropped_cnt <= dropped_cnt + 16'd1;
    end
  end

  adc_ring_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (adc_clk),
    .rst_n   (rst_n),
    .wr_addr (wr_ptr),
    .wr_data (adc_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  assign out_data = rd_word;

endmodule

// File: tb/tb_adc_window_buffer.sv
// Self-checking bench for adc_window_buffer.
// A per-cycle sample history serves as the reference model.
module tb_adc_window_buffer;

  localparam int N_CH     = 64;
  localparam int SAMPLE_W = 12;
  localparam int DEPTH    = 128;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int WIN_W    = 8;
  localparam int TW       = N_CH * SAMPLE_W;

  typedef logic [N_CH-1:0][SAMPLE_W-1:0] word_t;

  logic              adc_clk = 1'b0;
  logic              rst_n;
  word_t             adc_data;
  logic              trigger;
  logic [PTR_W-1:0]  trigger_latency;
  logic [WIN_W-1:0]  window_len;
  word_t             out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;
  logic              out_abort;
  logic              busy;
  logic              overrun;
  logic [15:0]       dropped_cnt;
  logic              clr_status;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    exp_drop = 0;
  bit    ramp_mode = 1'b1;
  word_t hist [int];

  always #5 adc_clk = ~adc_clk;

  adc_window_buffer #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .WIN_W    (WIN_W)
  ) dut (
    .adc_clk         (adc_clk),
    .rst_n           (rst_n),
    .adc_data        (adc_data),
    .trigger         (trigger),
    .trigger_latency (trigger_latency),
    .window_len      (window_len),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_first       (out_first),
    .out_last        (out_last),
    .out_abort       (out_abort),
    .busy            (busy),
    .overrun         (overrun),
    .dropped_cnt     (dropped_cnt),
    .clr_status      (clr_status)
  );

  function automatic word_t gen(input int idx);
    word_t w;
    for (int k = 0; k < N_CH; k++)
      w[k] = ramp_mode ? SAMPLE_W'(idx + k) : SAMPLE_W'($urandom);
    return w;
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] obs,
                       input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the word for the next edge is logged as hist[cyc+1].
  task automatic tick();
    word_t nxt;
    @(posedge adc_clk);
    cyc++;
    #1;
    nxt = gen(cyc + 1);
    adc_data = nxt;
    hist[cyc + 1] = nxt;
  endtask

  // mode: 0 ready high, 1 toggling, 3 random with bounded stalls
  task automatic run_window(input int lat, input int wl, input int mode,
                            input bit trig_end);
    int    t, leff, n, stalls;
    bit    done, rdy, prev_stall;
    word_t prev;
    leff = (lat > DEPTH - 2) ? DEPTH - 2 : lat;
    trigger_latency = PTR_W'(lat);
    window_len = WIN_W'(wl);
    trigger = 1'b1;
    tick();
    t = cyc;
    trigger = 1'b0;
    check("busy_start", busy, 1);
    check("valid_at_trig", out_valid, 0);
    n = 0; done = 0; prev_stall = 0; stalls = 0; prev = '0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = k[0];
      else                rdy = ($urandom_range(0, 1) == 1) || (stalls >= 20);
      out_ready = rdy;
      if (out_valid && prev_stall) check("stable_data", out_data, prev);
      if (out_valid) begin
        if (mode == 0 && n == 0) check("valid_rise", cyc - t, 1);
        if (rdy) begin
          check("beat_data", out_data, hist[t - leff + n]);
          check("beat_first", out_first, (n == 0));
          check("beat_last", out_last, (n == wl - 1));
          check("beat_abort", out_abort, 0);
          n++;
          done = out_last;
          if (done && trig_end) begin
            trigger = 1'b1;
            exp_drop++;
          end
        end else begin
          stalls++;
        end
      end
      prev_stall = out_valid && !rdy;
      prev = out_data;
      tick();
      trigger = 1'b0;
    end
    check("beat_count", n, wl);
    check("window_done", done, 1);
    if (mode == 0) check("end_time", cyc - t, 1 + wl);
    check("busy_end", busy, 0);
    check("valid_end", out_valid, 0);
    if (trig_end) check("drop_at_end", dropped_cnt, exp_drop);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    trigger = 1'b0;
    clr_status = 1'b0;
    out_ready = 1'b0;
    trigger_latency = '0;
    window_len = '0;
    adc_data = gen(1);
    hist[1] = adc_data;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_flags", {out_first, out_last, out_abort}, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_dropped", dropped_cnt, 0);
    rst_n = 1'b1;
    repeat (DEPTH + 4) tick();
    out_ready = 1'b1;

    // zero-length trigger is neither accepted nor counted
    window_len = '0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("wl0_busy", busy, 0);
    tick();
    check("wl0_valid", out_valid, 0);
    check("wl0_dropped", dropped_cnt, 0);

    run_window(10, 4, 0, 1'b0);
    run_window(0, 1, 0, 1'b0);
    run_window(3, 8, 1, 1'b0);
    run_window(DEPTH - 1, 5, 0, 1'b1);

    ramp_mode = 1'b0;
    repeat (8) run_window($urandom_range(0, DEPTH - 1), $urandom_range(1, 12), 0, 1'b0);
    repeat (8) run_window($urandom_range(0, 60), $urandom_range(1, 16), 3, 1'b0);

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    exp_drop = 0;
    check("clr_dropped", dropped_cnt, 0);

    // stalled window overruns; triggers while busy are counted
    out_ready = 1'b0;
    trigger_latency = PTR_W'(5);
    window_len = WIN_W'(16);
    trigger = 1'b1;
    tick();
    t = cyc;
    repeat (3) tick();
    trigger = 1'b0;
    check("drop_three", dropped_cnt, 3);
    check("no_overrun_yet", overrun, 0);
    repeat (DEPTH - 4) tick();
    check("ovr_valid", out_valid, 1);
    check("ovr_flags", {out_first, out_last, out_abort}, 3'b111);
    check("ovr_data", out_data, hist[t - 5]);
    check("ovr_sticky", overrun, 1);
    check("ovr_busy", busy, 1);
    trigger = 1'b1;
    repeat (70000) tick();
    check("drop_sat", dropped_cnt, 16'hFFFF);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    trigger = 1'b0;
    check("clr_wins_drop", dropped_cnt, 0);
    check("clr_overrun", overrun, 0);
    check("ovr_held_flags", {out_last, out_abort}, 2'b11);
    out_ready = 1'b1;
    tick();
    check("ovr_idle", busy, 0);
    check("ovr_valid_end", out_valid, 0);

    // asynchronous reset in the middle of a window
    trigger_latency = PTR_W'(3);
    window_len = WIN_W'(20);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", out_data, 0);
    check("arst_flags", {out_first, out_last, out_abort}, 0);
    repeat (3) tick();
    check("arst_hold", out_valid, 0);
    rst_n = 1'b1;
    repeat (DEPTH + 2) tick();
    check("post_rst_idle", {busy, out_valid}, 0);
    run_window(20, 6, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
